// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one pmem port between CPU fetch (inst) and MEM stage (data).
// Optional macro ARB_RR_EN: round-robin priority replaces fixed data priority + starvation guard.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_read,
  input  logic                  inst_write,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic [DATA_WIDTH-1:0] inst_wdata,
  input  logic [1:0]            inst_byte_enable,
  output logic                  inst_resp,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  input  logic [1:0]            data_byte_enable,
  output logic                  data_resp,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [DATA_WIDTH-1:0] pmem_wdata,
  output logic [1:0]            pmem_byte_enable,
  input  logic                  pmem_resp,
  input  logic [DATA_WIDTH-1:0] pmem_rdata,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a requester is pending while read|write is high and holds its request
  // stable until its one-cycle resp; the grant lasts from IDLE exit until pmem_resp.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   inst_pend, data_pend, pick_inst;

  assign inst_pend   = inst_read | inst_write;
  assign data_pend   = data_read | data_write;
  assign dbg_state_o = state_q;

  // Read data is a pass-through; held at 0 while reset is asserted.
  assign inst_rdata = rst_n ? pmem_rdata : '0;
  assign data_rdata = rst_n ? pmem_rdata : '0;

`ifdef ARB_RR_EN
  // rr pointer: 1 = data was granted last, 0 = inst was granted last.
  logic rr_q, rr_d;

  assign pick_inst = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && state_d == GRANT_I) rr_d = 1'b0;
    if (state_q == IDLE && state_d == GRANT_D) rr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b1;
    else        rr_q <= rr_d;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;

  assign pick_inst = (starve_q == LIMIT);

  // Counts data grants taken while inst waits; saturates so inst wins next.
  always_comb begin
    starve_d = starve_q;
    if (!inst_pend || (state_q == IDLE && state_d == GRANT_I)) begin
      starve_d = 4'd0;
    end else if (state_q == IDLE && state_d == GRANT_D) begin
      starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= 4'd0;
    else        starve_q <= starve_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    inst_resp        = 1'b0;
    data_resp        = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    pmem_byte_enable = 2'b00;
    case (state_q)
      IDLE: begin
        if (inst_pend && data_pend) state_d = pick_inst ? GRANT_I : GRANT_D;
        else if (inst_pend)         state_d = GRANT_I;
        else if (data_pend)         state_d = GRANT_D;
      end
      GRANT_I: begin
        pmem_read        = inst_read & ~inst_write;
        pmem_write       = inst_write;
        pmem_address     = inst_addr;
        pmem_wdata       = inst_wdata;
        pmem_byte_enable = inst_byte_enable;
        // A withdrawn request ends the grant without a resp.
        if (!inst_pend) begin
          state_d = IDLE;
        end else if (pmem_resp) begin
          inst_resp = 1'b1;
          state_d   = IDLE;
        end
      end
      GRANT_D: begin
        pmem_read        = data_read & ~data_write;
        pmem_write       = data_write;
        pmem_address     = data_addr;
        pmem_wdata       = data_wdata;
        pmem_byte_enable = data_byte_enable;
        if (!data_pend) begin
          state_d = IDLE;
        end else if (pmem_resp) begin
          data_resp = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks for mem_arbiter (default build: fixed data priority + starvation guard).
module tb_mem_arbiter;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inst_read, inst_write, data_read, data_write;
  logic [AW-1:0] inst_addr, data_addr, pmem_address;
  logic [DW-1:0] inst_wdata, data_wdata, pmem_wdata, pmem_rdata;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic [1:0]    inst_byte_enable, data_byte_enable, pmem_byte_enable;
  logic          inst_resp, data_resp, pmem_read, pmem_write, pmem_resp;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  // Expected grant: {read, write, addr, wdata, be}
  logic [35:0] exp_q[$];

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_read(inst_read), .inst_write(inst_write), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_byte_enable(inst_byte_enable),
    .inst_resp(inst_resp), .inst_rdata(inst_rdata),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_byte_enable(data_byte_enable),
    .data_resp(data_resp), .data_rdata(data_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_strobes"}, {pmem_read, pmem_write}, 2'b00);
    check({tag, "_addr"}, pmem_address, 16'h0000);
    check({tag, "_state"}, dbg_state, 2'd0);
  endtask

  task automatic check_grant(input string tag);
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable}, e);
    end
  endtask

  task automatic clear_reqs();
    inst_read = 1'b0; inst_write = 1'b0; inst_addr = '0; inst_wdata = '0; inst_byte_enable = 2'b00;
    data_read = 1'b0; data_write = 1'b0; data_addr = '0; data_wdata = '0; data_byte_enable = 2'b00;
  endtask

  // The two resps must never overlap.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      assert (!(inst_resp && data_resp)) else begin
        bad++;
        $error("FAIL resp_overlap observed=11 expected=not both");
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        i_act, d_act, win_i;
    int          d_streak;
    logic [15:0] r;

    rst_n = 1'b0; pmem_resp = 1'b0; pmem_rdata = 16'h5A5A;
    clear_reqs();
    repeat (3) tick();

    // Reset values
    check("rst_strobes", {pmem_read, pmem_write}, 2'b00);
    check("rst_resps", {inst_resp, data_resp}, 2'b00);
    check("rst_addr_wd_be", {pmem_address, pmem_wdata, pmem_byte_enable}, 34'h0);
    check("rst_rdatas", {inst_rdata, data_rdata}, 32'h0);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1; pmem_rdata = 16'h0000;
    tick();
    check_idle("post_rst");

    // Single fetch
    inst_read = 1'b1; inst_addr = 16'h0010; inst_byte_enable = 2'b11;
    #1 check("fetch_latency", pmem_read, 1'b0);
    tick();
    check("fetch_rd", {pmem_read, pmem_write, pmem_address}, {2'b10, 16'h0010});
    pmem_resp = 1'b1; pmem_rdata = 16'h1234;
    #1 check("fetch_resp", {inst_resp, data_resp, inst_rdata}, {2'b10, 16'h1234});
    tick();
    pmem_resp = 1'b0; clear_reqs();
    #1 check_idle("fetch_done");

    // Both pending: data store wins, then turnaround, then inst
    inst_read = 1'b1; inst_addr = 16'h0020;
    data_write = 1'b1; data_addr = 16'h0200; data_wdata = 16'hBEEF; data_byte_enable = 2'b10;
    tick();
    check("both_grant_d", {pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable},
          {2'b01, 16'h0200, 16'hBEEF, 2'b10});
    pmem_resp = 1'b1;
    #1 check("both_d_resp", {inst_resp, data_resp}, 2'b01);
    tick();
    pmem_resp = 1'b0; data_write = 1'b0;
    #1 check_idle("both_turnaround");
    tick();
    check("both_grant_i", {pmem_read, pmem_write, pmem_address, dbg_state}, {2'b10, 16'h0020, 2'd1});
    pmem_resp = 1'b1;
    #1 check("both_i_resp", {inst_resp, data_resp}, 2'b10);
    tick();
    pmem_resp = 1'b0; clear_reqs();

    // Starvation guard: inst held, data re-requests -> D,D,D,D,I
    inst_read = 1'b1; inst_addr = 16'h0030;
    data_read = 1'b1; data_addr = 16'h0100;
    for (int g = 0; g < 5; g++) begin
      tick();
      check($sformatf("starve_order_%0d", g), pmem_address == 16'h0030, g == 4);
      pmem_resp = 1'b1; pmem_rdata = 16'(g);
      #1 check($sformatf("starve_resp_%0d", g), {inst_resp, data_resp}, (g == 4) ? 2'b10 : 2'b01);
      tick();
      pmem_resp = 1'b0;
      if (g == 4) clear_reqs();
      else data_addr = data_addr + 16'h1;
    end

    // Asynchronous reset during GRANT_D
    data_write = 1'b1; data_addr = 16'h0300; data_wdata = 16'h7777; data_byte_enable = 2'b11;
    tick();
    check("midrst_grant", {pmem_write, dbg_state}, {1'b1, 2'd2});
    #2 rst_n = 1'b0;
    #1 check("midrst_drop", {pmem_read, pmem_write, data_resp, dbg_state}, 5'b0);
    clear_reqs();
    tick(); tick();
    rst_n = 1'b1;
    #1 check_idle("midrst_release");
    check("midrst_no_resp", data_resp, 1'b0);
    tick();
    check_idle("midrst_after");

    // pmem_resp while idle is ignored
    pmem_resp = 1'b1; pmem_rdata = 16'hCAFE;
    #1 check("idle_resp_ignored", {inst_resp, data_resp}, 2'b00);
    tick();
    pmem_resp = 1'b0;
    check_idle("idle_resp_state");

    // Granted inst withdraws; pending data granted after one IDLE cycle
    inst_read = 1'b1; inst_addr = 16'h0040;
    tick();
    check("wd_grant_i", {pmem_read, dbg_state}, {1'b1, 2'd1});
    inst_read = 1'b0; data_read = 1'b1; data_addr = 16'h0050;
    #1 check("wd_strobe_drop", {pmem_read, pmem_write, inst_resp}, 3'b000);
    tick();
    check_idle("wd_idle");
    check("wd_no_inst_resp", inst_resp, 1'b0);
    tick();
    check("wd_grant_d", {pmem_read, pmem_address, dbg_state}, {1'b1, 16'h0050, 2'd2});
    pmem_resp = 1'b1;
    #1 check("wd_d_resp", {inst_resp, data_resp}, 2'b01);
    tick();
    pmem_resp = 1'b0; clear_reqs();

    // Randomized traffic against a transaction-level model:
    // data wins ties, except that after LIMIT data wins in a row while inst waits, inst wins.
    i_act = 1'b0; d_act = 1'b0; d_streak = 0;
    for (int n = 0; n < 80; n++) begin
      if (!i_act && $urandom_range(0, 99) < 50) begin
        i_act = 1'b1; d_streak = 0;
        inst_read = 1'b1; inst_write = 1'b0;
        inst_addr = 16'($urandom); inst_wdata = 16'($urandom);
        inst_byte_enable = 2'($urandom_range(0, 3));
      end
      if (!d_act && ($urandom_range(0, 99) < 80 || !i_act)) begin
        int op;
        d_act = 1'b1;
        op = $urandom_range(0, 2);
        data_read = (op != 1); data_write = (op != 0);
        data_addr = 16'($urandom); data_wdata = 16'($urandom);
        data_byte_enable = 2'($urandom_range(0, 3));
      end
      #1 check("rnd_idle", {pmem_read, pmem_write, dbg_state}, 4'b0);

      if (i_act && d_act) win_i = (d_streak == LIMIT);
      else                win_i = i_act;
      if (win_i) d_streak = 0;
      else if (i_act) d_streak = (d_streak < LIMIT) ? d_streak + 1 : LIMIT;

      if (win_i) exp_q.push_back({inst_read & ~inst_write, inst_write, inst_addr, inst_wdata, inst_byte_enable});
      else       exp_q.push_back({data_read & ~data_write, data_write, data_addr, data_wdata, data_byte_enable});

      tick();
      check("rnd_state", dbg_state, win_i ? 2'd1 : 2'd2);
      check_grant("rnd_grant");
      repeat ($urandom_range(0, 2)) begin
        check("rnd_wait_resp", {inst_resp, data_resp}, 2'b00);
        tick();
      end
      r = 16'($urandom);
      pmem_resp = 1'b1; pmem_rdata = r;
      #1 check("rnd_resp", {inst_resp, data_resp, inst_rdata, data_rdata}, {win_i, ~win_i, r, r});
      tick();
      pmem_resp = 1'b0;
      if (win_i) begin
        i_act = 1'b0; inst_read = 1'b0; inst_write = 1'b0;
      end else begin
        d_act = 1'b0; data_read = 1'b0; data_write = 1'b0;
      end
    end
    check("rnd_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
